// File: rtl/step_sequencer.sv
// Stepper-motor step sequencer: on a rising edge of start, issues step_count
// one-hot phase rotations spaced step_period clocks apart, with abort support.
module step_sequencer #(
    parameter int unsigned STEP_W   = 16,
    parameter int unsigned PERIOD_W = 16
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                start,
    input  logic                abort,
    input  logic                direction,
    input  logic [STEP_W-1:0]   step_count,
    input  logic [PERIOD_W-1:0] step_period,
    output logic [3:0]          phase,
    output logic                step_pulse,
    output logic                busy,
    output logic                done,
    output logic [STEP_W-1:0]   steps_remaining
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t                state;
    state_t                state_d;
    logic [1:0]            start_hist;
    logic                  start_edge_c;
    logic                  dir_q;
    logic                  dir_d;
    logic [PERIOD_W-1:0]   reload_q;
    logic [PERIOD_W-1:0]   reload_d;
    logic [PERIOD_W-1:0]   period_cnt;
    logic [PERIOD_W-1:0]   period_cnt_d;
    logic [PERIOD_W-1:0]   load_reload_c;
    logic [3:0]            phase_d;
    logic [3:0]            phase_rot_c;
    logic [STEP_W-1:0]     remaining_d;
    logic                  step_pulse_d;
    logic                  busy_d;
    logic                  done_d;

    assign start_edge_c  = (start_hist == 2'b01);
    // A zero period behaves as a period of one clock.
    assign load_reload_c = (step_period == '0) ? '0 : step_period - PERIOD_W'(1);
    assign phase_rot_c   = dir_q ? {phase[2:0], phase[3]} : {phase[0], phase[3:1]};

    // State register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Next-state and datapath next values
    always_comb begin
        state_d      = state;
        dir_d        = dir_q;
        reload_d     = reload_q;
        period_cnt_d = period_cnt;
        phase_d      = phase;
        remaining_d  = steps_remaining;
        step_pulse_d = 1'b0;
        done_d       = 1'b0;

        case (state)
            IDLE: begin
                if (start_edge_c) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                if (abort) begin
                    state_d = IDLE;
                end else begin
                    dir_d        = direction;
                    reload_d     = load_reload_c;
                    period_cnt_d = load_reload_c;
                    remaining_d  = step_count;
                    state_d      = (step_count == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                // Abort takes priority over a step falling due in the same clock.
                if (abort) begin
                    state_d = IDLE;
                end else if (period_cnt != '0) begin
                    period_cnt_d = period_cnt - PERIOD_W'(1);
                end else begin
                    step_pulse_d = 1'b1;
                    phase_d      = phase_rot_c;
                    remaining_d  = steps_remaining - STEP_W'(1);
                    period_cnt_d = reload_q;
                    if (steps_remaining <= STEP_W'(1)) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d == LOAD) || (state_d == RUN);
    end

    // Registered datapath and outputs
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            start_hist      <= 2'b00;
            dir_q           <= 1'b0;
            reload_q        <= '0;
            period_cnt      <= '0;
            phase           <= 4'b0001;
            steps_remaining <= '0;
            step_pulse      <= 1'b0;
            busy            <= 1'b0;
            done            <= 1'b0;
        end else begin
            start_hist      <= {start_hist[0], start};
            dir_q           <= dir_d;
            reload_q        <= reload_d;
            period_cnt      <= period_cnt_d;
            phase           <= phase_d;
            steps_remaining <= remaining_d;
            step_pulse      <= step_pulse_d;
            busy            <= busy_d;
            done            <= done_d;
        end
    end

endmodule

// File: tb/tb_step_sequencer.sv
// Scoreboard bench for step_sequencer: stimulus queues expected step/done
// events, a negedge monitor pops and compares them as the DUT emits them.
module tb_step_sequencer;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        direction = 1'b0;
    logic [15:0] step_count = '0;
    logic [15:0] step_period = '0;
    logic [3:0]  phase;
    logic        step_pulse;
    logic        busy;
    logic        done;
    logic [15:0] steps_remaining;

    step_sequencer #(.STEP_W(16), .PERIOD_W(16)) dut (
        .clock           (clock),
        .reset_n         (reset_n),
        .start           (start),
        .abort           (abort),
        .direction       (direction),
        .step_count      (step_count),
        .step_period     (step_period),
        .phase           (phase),
        .step_pulse      (step_pulse),
        .busy            (busy),
        .done            (done),
        .steps_remaining (steps_remaining)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        bit          is_done;
        int          cyc;
        logic [3:0]  ph;
        logic [15:0] rem;
        logic        bsy;
    } ev_t;

    ev_t        exp_q[$];
    int         n_checks = 0;
    int         n_fail = 0;
    logic [3:0] model_phase = 4'b0001;

    function automatic logic [3:0] rot(input logic [3:0] p, input logic d);
        return d ? {p[2:0], p[3]} : {p[0], p[3:1]};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // Expected events for a move whose start was driven in cycle t0.
    task automatic push_move(input int t0, input logic d, input int cnt, input int per,
                             input int npulse, input bit with_done);
        int         pe;
        logic [3:0] ph;
        ev_t        e;
        pe = (per == 0) ? 1 : per;
        ph = model_phase;
        for (int k = 1; k <= npulse; k++) begin
            ph        = rot(ph, d);
            e.is_done = 1'b0;
            e.cyc     = t0 + 3 + k * pe;
            e.ph      = ph;
            e.rem     = 16'(cnt - k);
            e.bsy     = (k != cnt);
            exp_q.push_back(e);
        end
        if (with_done) begin
            e.is_done = 1'b1;
            e.cyc     = t0 + 3 + cnt * pe + 1;
            e.ph      = ph;
            e.rem     = 16'd0;
            e.bsy     = 1'b0;
            exp_q.push_back(e);
        end
        model_phase = ph;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    // Pulse start, hold config through LOAD, then scramble config inputs.
    task automatic drive_start(input logic d, input int cnt, input int per,
                               input int npulse, input bit with_done, output int t0);
        @(posedge clock);
        #1;
        direction   = d;
        step_count  = 16'(cnt);
        step_period = 16'(per);
        start       = 1'b1;
        t0          = cyc;
        push_move(t0, d, cnt, per, npulse, with_done);
        wait_cycles(1);
        start = 1'b0;
        wait_cycles(2);
        direction   = ~d;
        step_count  = 16'h00F3;
        step_period = 16'h0002;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_phase"}, phase, 4'b0001);
        check({tag, "_step_pulse"}, step_pulse, 1'b0);
        check({tag, "_busy"}, busy, 1'b0);
        check({tag, "_done"}, done, 1'b0);
        check({tag, "_steps_remaining"}, steps_remaining, 16'd0);
    endtask

    // Monitor: every strobe must match the head of the expected queue.
    always @(negedge clock) begin
        ev_t e;
        if (reset_n && (step_pulse || done)) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_event: pulse=%0b done=%0b at cycle %0d, expected none",
                         step_pulse, done, cyc);
            end else begin
                e = exp_q.pop_front();
                check("ev_done", done, e.is_done);
                check("ev_pulse", step_pulse, !e.is_done);
                check("ev_cycle", cyc, e.cyc);
                check("ev_phase", phase, e.ph);
                check("ev_steps_remaining", steps_remaining, e.rem);
                check("ev_busy", busy, e.bsy);
            end
        end
    end

    initial begin
        int t0;

        #23 reset_n = 1'b1;
        @(negedge clock);
        check_reset_outputs("por");

        // Forward 3 steps, period 4
        drive_start(1'b1, 3, 4, 3, 1'b1, t0);
        wait_cycles(25);
        check("drained_fwd3", exp_q.size(), 0);

        // Zero-step move: done only, phase unchanged
        drive_start(1'b1, 0, 7, 0, 1'b1, t0);
        wait_cycles(10);
        check("drained_zero", exp_q.size(), 0);

        // Period 0 acts as 1, reverse direction
        drive_start(1'b0, 2, 0, 2, 1'b1, t0);
        wait_cycles(10);
        check("drained_p0", exp_q.size(), 0);

        // Abort after the 4th of 10 steps
        drive_start(1'b1, 10, 5, 4, 1'b0, t0);
        wait_cycles(20);
        abort = 1'b1;
        wait_cycles(1);
        abort = 1'b0;
        @(negedge clock);
        check("abort_busy", busy, 1'b0);
        check("abort_steps_remaining", steps_remaining, 16'd6);
        check("abort_phase", phase, model_phase);
        check("abort_pulse", step_pulse, 1'b0);
        wait_cycles(40);
        check("drained_abort", exp_q.size(), 0);

        // Start held high, second edge while busy ignored
        @(posedge clock);
        #1;
        direction   = 1'b1;
        step_count  = 16'd3;
        step_period = 16'd2;
        start       = 1'b1;
        t0          = cyc;
        push_move(t0, 1'b1, 3, 2, 3, 1'b1);
        wait_cycles(5);
        start = 1'b0;
        wait_cycles(1);
        start = 1'b1;
        wait_cycles(19);
        start = 1'b0;
        wait_cycles(10);
        check("drained_held", exp_q.size(), 0);

        // Asynchronous reset mid-RUN, then start held through reset release
        drive_start(1'b1, 5, 3, 1, 1'b0, t0);
        wait_cycles(4);
        #3 reset_n = 1'b0;
        #1;
        check_reset_outputs("mid_reset");
        model_phase = 4'b0001;
        direction   = 1'b1;
        step_count  = 16'd1;
        step_period = 16'd1;
        start       = 1'b1;
        wait_cycles(2);
        #2 reset_n = 1'b1;
        t0 = cyc;
        push_move(t0, 1'b1, 1, 1, 1, 1'b1);
        wait_cycles(8);
        start = 1'b0;
        wait_cycles(10);
        check("drained_reset", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
